// File: rtl/dyna85_pkg.sv
// dyna85_pkg: shared types and helpers for the Dyna-85 fetch front end.
//   state_e       fetch sequencer FSM states
//   OPC_HLT       halt opcode
//   instr_length  opcode -> instruction length in bytes (1..3)
package dyna85_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_OP,
    S_FETCH_B2,
    S_FETCH_B3,
    S_ISSUE,
    S_HALT
  } state_e;

  localparam logic [7:0] OPC_HLT = 8'h76;

  function automatic logic [1:0] instr_length(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    case (op)
      8'h01, 8'h11, 8'h21, 8'h31, 8'h22,
      8'h2A, 8'h32, 8'h3A, 8'hC3, 8'hCD: len = 2'd3;
      8'hD3, 8'hDB:                      len = 2'd2;
      default: begin
        // Conditional jumps/calls carry a 16-bit address.
        if (op[7:6] == 2'b11 && (op[2:0] == 3'b010 || op[2:0] == 3'b100))
          len = 2'd3;
        // MVI r,d8 and the ALU-immediate group carry one data byte.
        else if ((op[7:6] == 2'b00 || op[7:6] == 2'b11) && op[2:0] == 3'b110)
          len = 2'd2;
      end
    endcase
    return len;
  endfunction

endpackage

// File: rtl/fetch_sequencer_length_decoder.sv
// length_decoder: combinational opcode length decode.
//   opcode  in   opcode byte
//   len     out  instruction length in bytes (1, 2 or 3)
module length_decoder
  import dyna85_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  always_comb len = instr_length(opcode);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: Dyna-85 instruction fetch controller.
// Reads opcode and operand bytes at the PC over a req/ack memory port,
// strobes the opcode into the instruction register, and presents the
// assembled instruction to execute over valid/ready. Handles branch
// redirects and the HLT opcode.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   run                        enable fetching (sampled in IDLE/ISSUE)
//   mem_rd_req/addr/ack/rdata  byte read port
//   ir_load, ir_data           one-cycle opcode load strobe
//   instr_valid/ready          instruction handshake to execute
//   instr_opcode/operand/len/pc  captured instruction
//   branch_valid/target        redirect request
//   resume                     leave HALT
//   pc, halted                 status
// Build option: FETCH_STATS_EN adds instr_count, a saturating count of
// accepted instructions.
module fetch_sequencer
  import dyna85_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              ir_load,
  output logic [7:0]        ir_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [15:0]       instr_operand,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]       instr_count
`endif
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [15:0]       operand_q, operand_d;
  logic [1:0]        len_q, len_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              ir_load_q, ir_load_d;
  logic [7:0]        ir_data_q, ir_data_d;
  logic              br_pend_q, br_pend_d;
  logic [ADDR_W-1:0] br_tgt_q, br_tgt_d;
  logic              fetching;
  logic [1:0]        dec_len;

  length_decoder u_len (.opcode(mem_rdata), .len(dec_len));

  assign fetching = (state_q == S_FETCH_OP) || (state_q == S_FETCH_B2) ||
                    (state_q == S_FETCH_B3);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    len_d     = len_q;
    ipc_d     = ipc_q;
    ir_load_d = 1'b0;
    ir_data_d = ir_data_q;
    br_pend_d = br_pend_q;
    br_tgt_d  = br_tgt_q;
    case (state_q)
      S_IDLE: begin
        if (branch_valid) pc_d = branch_target;
        if (run) state_d = S_FETCH_OP;
      end
      S_FETCH_OP, S_FETCH_B2, S_FETCH_B3: begin
        if (mem_ack) begin
          if (branch_valid || br_pend_q) begin
            // Redirect: the returning byte belongs to the old stream.
            // A fresh branch this cycle wins over an older pending one.
            pc_d      = branch_valid ? branch_target : br_tgt_q;
            br_pend_d = 1'b0;
            state_d   = S_FETCH_OP;
          end else begin
            pc_d = pc_q + PC_ONE;
            case (state_q)
              S_FETCH_OP: begin
                opcode_d  = mem_rdata;
                ipc_d     = pc_q;
                operand_d = '0;
                len_d     = dec_len;
                ir_load_d = 1'b1;
                ir_data_d = mem_rdata;
                state_d   = (dec_len == 2'd1) ? S_ISSUE : S_FETCH_B2;
              end
              S_FETCH_B2: begin
                operand_d[7:0] = mem_rdata;
                state_d        = (len_q == 2'd2) ? S_ISSUE : S_FETCH_B3;
              end
              default: begin
                operand_d[15:8] = mem_rdata;
                state_d         = S_ISSUE;
              end
            endcase
          end
        end else if (branch_valid) begin
          // The request in flight must still complete; remember where to go.
          br_pend_d = 1'b1;
          br_tgt_d  = branch_target;
        end
      end
      S_ISSUE: begin
        if (branch_valid) begin
          pc_d    = branch_target;
          state_d = S_FETCH_OP;
        end else if (instr_ready) begin
          if (opcode_q == OPC_HLT) state_d = S_HALT;
          else if (run)            state_d = S_FETCH_OP;
          else                     state_d = S_IDLE;
        end
      end
      S_HALT: begin
        if (branch_valid) begin
          pc_d    = branch_target;
          state_d = S_FETCH_OP;
        end else if (resume) begin
          state_d = S_FETCH_OP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      opcode_q  <= '0;
      operand_q <= '0;
      len_q     <= '0;
      ipc_q     <= '0;
      ir_load_q <= 1'b0;
      ir_data_q <= '0;
      br_pend_q <= 1'b0;
      br_tgt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len_q     <= len_d;
      ipc_q     <= ipc_d;
      ir_load_q <= ir_load_d;
      ir_data_q <= ir_data_d;
      br_pend_q <= br_pend_d;
      br_tgt_q  <= br_tgt_d;
    end
  end

  assign mem_rd_req    = fetching;
  assign mem_addr      = fetching ? pc_q : '0;
  assign ir_load       = ir_load_q;
  assign ir_data       = ir_data_q;
  assign instr_valid   = (state_q == S_ISSUE);
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign instr_len     = len_q;
  assign instr_pc      = ipc_q;
  assign pc            = pc_q;
  assign halted        = (state_q == S_HALT);

`ifdef FETCH_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (instr_valid && instr_ready && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the Dyna-85 core. Sequences memory reads at the PC and loads the opcode register via `ir_load`/`ir_data`.
- Decodes instruction length from the opcode (1–3 bytes), fetches the operand bytes, and presents a complete instruction to the execute stage over a valid/ready handshake.
- Handles branch redirects and the HLT opcode (8'h76).

Parameters:
- ADDR_W, 16, width of PC and memory address.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  enables fetching; sampled in IDLE and in ISSUE.
- mem_rd_req  out  1  memory read request.
- mem_addr  out  ADDR_W  read address; stable while mem_rd_req=1.
- mem_ack  in  1  read complete; mem_rdata valid this cycle.
- mem_rdata  in  8  read data.
- ir_load  out  1  one-cycle load strobe to the instruction register.
- ir_data  out  8  opcode byte for the instruction register.
- instr_valid  out  1  complete instruction available.
- instr_ready  in  1  execute stage accepts the instruction.
- instr_opcode  out  8  captured opcode.
- instr_operand  out  16  {byte3,byte2}; unused bytes are 0.
- instr_len  out  2  1, 2 or 3.
- instr_pc  out  ADDR_W  address of the opcode byte.
- branch_valid  in  1  redirect request.
- branch_target  in  ADDR_W  redirect address.
- resume  in  1  leave HALT.
- pc  out  ADDR_W  current fetch PC.
- halted  out  1  high in HALT.

Behaviour:
- Reset, synchronous: state=IDLE, pc=RESET_PC, all other outputs 0.
- States: IDLE, FETCH_OP, FETCH_B2, FETCH_B3, ISSUE, HALT.
- IDLE -> FETCH_OP when run=1.
- Fetch states:
  - mem_rd_req=1 and mem_addr=pc.
  - mem_rd_req stays high, address stable, until mem_ack.
  - Each ack sets pc <= pc+1 (wraps modulo 2^ADDR_W).
- FETCH_OP ack:
  - Capture opcode and instr_pc.
  - Next cycle: ir_load=1 for exactly one cycle, ir_data=opcode (registered).
  - Length 1 -> ISSUE; length 2 or 3 -> FETCH_B2.
- FETCH_B2 ack: byte2 -> operand[7:0]. Length 2 -> ISSUE; length 3 -> FETCH_B3.
- FETCH_B3 ack: byte3 -> operand[15:8]; -> ISSUE.
- ISSUE:
  - instr_valid=1; all instr_* outputs held stable until instr_ready.
  - On instr_ready: opcode 8'h76 -> HALT; else run=1 -> FETCH_OP; else -> IDLE.
  - instr_valid drops the cycle after the handshake.
- HALT: halted=1, no requests. resume or branch_valid -> FETCH_OP.
- Minimum latency: fetch to instr_valid = (acks) + 1 cycle.
- Length decode (package function):
  - 3 bytes: 01,11,21,31,22,2A,32,3A,C3,CD; and op[7:6]=11 with op[2:0] in {010,100}.
  - 2 bytes: op[7:6]=00 with op[2:0]=110; op[7:6]=11 with op[2:0]=110; D3; DB.
  - All others: 1 byte.
- Branch handling (branch_valid=1; branch has priority over normal transitions):
  - IDLE or HALT: pc <= target.
  - Fetch state with no ack this cycle: set a pending flag; the outstanding request completes, its data is discarded, no ir_load is issued, then pc <= target and -> FETCH_OP.
  - Fetch state with ack in the same cycle: data discarded, pc <= target, -> FETCH_OP.
  - ISSUE without instr_ready: instruction dropped, pc <= target, -> FETCH_OP.
  - ISSUE with instr_ready in the same cycle: instruction counts as issued; pc <= target.
- Reset mid-request: mem_rd_req drops the next cycle. The memory side must tolerate an abandoned request.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined: adds output instr_count [15:0]. It increments on each instr_valid&&instr_ready, saturates at 16'hFFFF, and clears on reset.
- Undefined: no port, no counter logic.

Decomposition:
- Package dyna85_pkg holds:
  - the state enum;
  - OPC_HLT = 8'h76;
  - the function instr_length(opcode) returning a 2-bit value.
- Sub-module: none required. A natural split, if wanted, is a combinational `length_decoder`.

Test Plan:
- Reset; run=1; memory holds 3E 55 at address 0000, ack 1 cycle later:
  - ir_load pulses with ir_data=3E;
  - instr_valid with opcode 3E, operand 0055, len 2, instr_pc 0000;
  - pc=0002.
- C3 34 12 with random ack delay of 0–3 cycles and instr_ready held low for 5 cycles: outputs stable; operand 1234, len 3; after ready, fetch resumes at pc=0003.
- 76 fetched:
  - after handshake, halted=1 and mem_rd_req stays 0 for 10 cycles;
  - resume -> fetch at 0001.
- branch_valid (target 0100) while FETCH_B2 awaits ack: ack data discarded, no instr_valid, next mem_addr=0100.
- pc=FFFF with a 1-byte opcode: after ack, pc=0000.
- Reset asserted during FETCH_B3: the next cycle shows state IDLE, all outputs 0, pc=0000.
